// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback, buffered long-latency results and starvation-forced drains.
// Optional RF_WB_SCOREBOARD_EN adds the busy-register scoreboard and the decode hazard flag.
module reg_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    input  logic        lr_valid,
    output logic        lr_ready,
    input  logic [4:0]  lr_rd,
    input  logic [31:0] lr_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  chk_rs,
    input  logic [4:0]  chk_rt,
    input  logic [4:0]  chk_rd,
    output logic        hazard,
    output logic [31:0] busy_mask,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SC_W   = 4;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [REG_W-1:0]  fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [SC_W-1:0]   starve_cnt;
    logic              empty;
    logic              pipe_slot;
    logic              force_drain;
    logic              drain;
    logic              enq;
    logic [REG_W-1:0]  head_rd;
    logic [DATA_W-1:0] head_data;

    assign empty       = (count == '0);
    assign pipe_slot   = pipe_we & (pipe_waddr != '0);
    assign force_drain = (starve_cnt == SC_W'(STARVE_LIMIT)) & ~empty;
    assign drain       = ~empty & (~pipe_slot | force_drain);
    assign pipe_stall  = force_drain;
    assign head_rd     = fifo_rd[rd_ptr];
    assign head_data   = fifo_data[rd_ptr];
    assign lr_ready    = (count < CNT_W'(FIFO_DEPTH));
    // Results for r0 are accepted but never occupy a slot.
    assign enq         = lr_valid & lr_ready & (lr_rd != '0);

    // Write-port mux; address/data follow the pipeline whenever nothing drains.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = pipe_waddr;
        rf_wdata = pipe_wdata;
        if (drain) begin
            rf_we    = 1'b1;
            rf_waddr = head_rd;
            rf_wdata = head_data;
        end else if (pipe_slot) begin
            rf_we = 1'b1;
        end
        if (!reset) begin
            rf_we = 1'b0;
        end
    end

    // Payload storage needs no reset: validity is carried by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= lr_rd;
            fifo_data[wr_ptr] <= lr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (drain) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(drain);
            // Non-empty without a drain means the pipeline took the slot.
            if (empty || drain) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] busy;
    logic [31:0] busy_next;

    function automatic logic sb_hit(input logic [REG_W-1:0] r, input logic [31:0] b,
                                    input logic d, input logic [REG_W-1:0] h);
        return (r != '0) && b[r] && !(d && (h == r));
    endfunction

    // A same-cycle issue to the draining register keeps it busy.
    always_comb begin
        busy_next = busy;
        if (drain) begin
            busy_next[head_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_mask = busy;
    assign hazard    = sb_hit(chk_rs, busy, drain, head_rd)
                     | sb_hit(chk_rt, busy, drain, head_rd)
                     | sb_hit(chk_rd, busy, drain, head_rd);
`else
    logic unused_sb;

    assign unused_sb = ^{issue_valid, issue_rd, chk_rs, chk_rt, chk_rd};
    assign busy_mask = '0;
    assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: expected long-latency writes are queued on acceptance
// and checked when they reach the register-file port.
module tb_reg_wb_arbiter;

`ifdef RF_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif
    localparam int NONE = 0;
    localparam int PIPE = 1;
    localparam int FIFO = 2;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;
    logic        lr_valid;
    logic        lr_ready;
    logic [4:0]  lr_rd;
    logic [31:0] lr_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs;
    logic [4:0]  chk_rt;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic [31:0] busy_mask;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [36:0] lr_q [$];
    int vectors     = 0;
    int miscompares = 0;

    reg_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall),
        .lr_valid(lr_valid), .lr_ready(lr_ready), .lr_rd(lr_rd), .lr_data(lr_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd),
        .hazard(hazard), .busy_mask(busy_mask),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
        pipe_we = we; pipe_waddr = a; pipe_wdata = d;
    endtask

    task automatic lr(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lr_valid = v; lr_rd = rd; lr_data = d;
    endtask

    task automatic iss(input logic v, input logic [4:0] rd);
        issue_valid = v; issue_rd = rd;
    endtask

    task automatic regs(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        chk_rs = rs; chk_rt = rt; chk_rd = rd;
    endtask

    // Compare the write port (by expected source) and the status outputs.
    task automatic chk(input string tag, input int src, input logic e_stall, input logic e_ready,
                       input logic e_haz, input logic [31:0] e_busy);
        logic        e_we;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [36:0] ent;
        #1;
        e_we = (src != NONE);
        ea   = pipe_waddr;
        ed   = pipe_wdata;
        if (src == FIFO) begin
            vectors++;
            assert (lr_q.size() != 0) else begin
                miscompares++;
                $error("FAIL %s scoreboard empty when a long result was expected", tag);
            end
            if (lr_q.size() != 0) begin
                ent = lr_q.pop_front();
                ea  = ent[36:32];
                ed  = ent[31:0];
            end
        end
        vectors++;
        assert (rf_we === e_we) else begin
            miscompares++;
            $error("FAIL %s rf_we got %0b want %0b", tag, rf_we, e_we);
        end
        if (e_we) begin
            vectors++;
            assert (rf_waddr === ea) else begin
                miscompares++;
                $error("FAIL %s rf_waddr got %0d want %0d", tag, rf_waddr, ea);
            end
            vectors++;
            assert (rf_wdata === ed) else begin
                miscompares++;
                $error("FAIL %s rf_wdata got %08h want %08h", tag, rf_wdata, ed);
            end
        end
        vectors++;
        assert (pipe_stall === e_stall) else begin
            miscompares++;
            $error("FAIL %s pipe_stall got %0b want %0b", tag, pipe_stall, e_stall);
        end
        vectors++;
        assert (lr_ready === e_ready) else begin
            miscompares++;
            $error("FAIL %s lr_ready got %0b want %0b", tag, lr_ready, e_ready);
        end
        vectors++;
        assert (hazard === (e_haz & SB)) else begin
            miscompares++;
            $error("FAIL %s hazard got %0b want %0b", tag, hazard, e_haz & SB);
        end
        vectors++;
        assert (busy_mask === (SB ? e_busy : 32'h0)) else begin
            miscompares++;
            $error("FAIL %s busy_mask got %08h want %08h", tag, busy_mask, SB ? e_busy : 32'h0);
        end
    endtask

    initial begin
        reset = 1'b0;
        pipe(1'b1, 5'd3, 32'h0000_0111);
        lr(1'b1, 5'd5, 32'h1234_5678);
        iss(1'b1, 5'd6);
        regs(5'd0, 5'd0, 5'd0);
        tick();
        chk("in_reset", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();

        // Idle pipeline: issue rd5, result arrives, drains the next cycle.
        reset = 1'b1;
        pipe(1'b0, 5'd0, 32'h0);
        lr(1'b0, 5'd0, 32'h0);
        iss(1'b1, 5'd5);
        chk("issue5", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        iss(1'b0, 5'd0);
        regs(5'd5, 5'd0, 5'd0);
        lr(1'b1, 5'd5, 32'hDEAD_BEEF);
        lr_q.push_back({5'd5, 32'hDEAD_BEEF});
        chk("offer5", NONE, 1'b0, 1'b1, 1'b1, 32'h0000_0020);
        tick();
        lr(1'b0, 5'd0, 32'h0);
        chk("drain5", FIFO, 1'b0, 1'b1, 1'b0, 32'h0000_0020);
        tick();
        chk("clear5", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        regs(5'd0, 5'd0, 5'd0);

        // Starvation: pipeline writes r3 every cycle, three results offered.
        pipe(1'b1, 5'd3, 32'h100);
        lr(1'b1, 5'd10, 32'hA0);
        lr_q.push_back({5'd10, 32'hA0});
        chk("st_d0", PIPE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        pipe(1'b1, 5'd3, 32'h101);
        lr(1'b1, 5'd11, 32'hB1);
        lr_q.push_back({5'd11, 32'hB1});
        chk("st_d1", PIPE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        pipe(1'b1, 5'd3, 32'h102);
        lr(1'b1, 5'd12, 32'hC2);
        chk("st_full_d2", PIPE, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        pipe(1'b1, 5'd3, 32'h103);
        chk("st_d3", PIPE, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        pipe(1'b1, 5'd3, 32'h104);
        chk("st_d4", PIPE, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        pipe(1'b1, 5'd3, 32'h105);
        chk("st_force_d5", FIFO, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        lr_q.push_back({5'd12, 32'hC2});
        chk("st_held_d6", PIPE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        pipe(1'b0, 5'd0, 32'h0);
        lr(1'b0, 5'd0, 32'h0);
        chk("st_d7", FIFO, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("st_d8", FIFO, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("st_idle", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();

        // Hazard on rd7, write-through exclusion, and set-wins on a same-cycle issue.
        iss(1'b1, 5'd7);
        chk("hz_issue7", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        iss(1'b0, 5'd0);
        regs(5'd7, 5'd0, 5'd0);
        chk("hz_rs7", NONE, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
        tick();
        regs(5'd0, 5'd0, 5'd7);
        chk("hz_rd7", NONE, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
        tick();
        lr(1'b1, 5'd7, 32'h77);
        lr_q.push_back({5'd7, 32'h77});
        chk("hz_offer7", NONE, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
        tick();
        lr(1'b0, 5'd0, 32'h0);
        regs(5'd7, 5'd0, 5'd0);
        iss(1'b1, 5'd7);
        chk("hz_drain7", FIFO, 1'b0, 1'b1, 1'b0, 32'h0000_0080);
        tick();
        iss(1'b1, 5'd10);
        regs(5'd0, 5'd7, 5'd0);
        chk("hz_setwins", NONE, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
        tick();
        iss(1'b0, 5'd0);
        regs(5'd0, 5'd0, 5'd0);

        // Queue two entries behind the pipeline, then reset asynchronously.
        pipe(1'b1, 5'd3, 32'h200);
        lr(1'b1, 5'd20, 32'h14);
        lr_q.push_back({5'd20, 32'h14});
        chk("rs_q0", PIPE, 1'b0, 1'b1, 1'b0, 32'h0000_0480);
        tick();
        pipe(1'b1, 5'd3, 32'h201);
        lr(1'b1, 5'd21, 32'h15);
        lr_q.push_back({5'd21, 32'h15});
        chk("rs_q1", PIPE, 1'b0, 1'b1, 1'b0, 32'h0000_0480);
        tick();
        pipe(1'b1, 5'd3, 32'h202);
        lr(1'b0, 5'd0, 32'h0);
        chk("rs_full", PIPE, 1'b0, 1'b0, 1'b0, 32'h0000_0480);
        reset = 1'b0;
        lr_q.delete();
        chk("rs_async", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        pipe(1'b0, 5'd0, 32'h0);
        chk("rs_nostale", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        lr(1'b1, 5'd6, 32'h66);
        lr_q.push_back({5'd6, 32'h66});
        chk("rs_first", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        lr(1'b0, 5'd0, 32'h0);
        chk("rs_wr6", FIFO, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();

        // r0 destinations: never written, never queued; a real entry drains past a pipe r0 write.
        pipe(1'b1, 5'd0, 32'h999);
        lr(1'b1, 5'd0, 32'h55);
        chk("z_offer0", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        lr(1'b1, 5'd4, 32'h44);
        lr_q.push_back({5'd4, 32'h44});
        chk("z_nothing", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        lr(1'b0, 5'd0, 32'h0);
        chk("z_drain4", FIFO, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("z_idle", NONE, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();

        vectors++;
        assert (lr_q.size() == 0) else begin
            miscompares++;
            $error("FAIL leftover %0d expected writes never seen, want 0", lr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
